// File: rtl/ps2_key_event_fifo_if.sv
// Key-event stream between ps2_key_event_fifo and its consumer.
// The master presents the FIFO head entry and the slave pops it with ready.
interface ps2_key_event_fifo_if;
    logic       valid;
    logic       ready;
    logic [7:0] code;
    logic       ext;
    logic       make;

    modport master (output valid, output code, output ext, output make, input ready);
    modport slave  (input valid, input code, input ext, input make, output ready);
endinterface

// File: rtl/ps2_key_event_fifo.sv
// PS/2 set-2 key event decoder with typematic-repeat suppression, press
// counter and a first-word-fall-through event queue.
module ps2_key_event_fifo #(
    parameter int FIFO_DEPTH      = 8,
    parameter int CNT_W           = 8,
    parameter int SUPPRESS_REPEAT = 1
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic [7:0]                    kb_data,
    input  logic                          kb_ready,
    input  logic                          kb_overflow,
    output logic                          kb_nextdata_n,
    ps2_key_event_fifo_if.master          evt,
    output logic [7:0]                    cur_code,
    output logic                          cur_ext,
    output logic                          key_held,
    output logic [CNT_W-1:0]              press_cnt,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          err,
    input  logic                          clr_err
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [1:0] {IDLE, ACK, SETTLE} state_t;

    typedef struct packed {
        logic       ext;
        logic [7:0] code;
        logic       make;
    } ev_t;

    state_t          state, state_nxt;
    logic [7:0]      byte_q;
    logic            ext_f, brk_f;

    ev_t             mem [FIFO_DEPTH];
    ev_t             head;
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [LW-1:0]   level;

    // Decode signals, only meaningful while in ACK.
    logic            in_ack, is_e0, is_f0, is_junk, evt_hit, match, rpt, take, take_make;
    ev_t             new_ev;
    logic            full, pop, wr, drop;

    // Intake state register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nxt;
    end

    // Intake next state; the pop strobe is low only for the ACK cycle.
    always_comb begin
        state_nxt     = state;
        kb_nextdata_n = 1'b1;
        case (state)
            IDLE:    if (kb_ready) state_nxt = ACK;
            ACK: begin
                kb_nextdata_n = 1'b0;
                state_nxt     = SETTLE;
            end
            SETTLE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Capture the offered byte when leaving IDLE.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)                       byte_q <= 8'h00;
        else if (state == IDLE && kb_ready) byte_q <= kb_data;
    end

    // Byte classification and repeat detection.
    always_comb begin
        in_ack    = (state == ACK);
        is_e0     = (byte_q == 8'hE0);
        is_f0     = (byte_q == 8'hF0);
        is_junk   = (byte_q == 8'h00) || (byte_q == 8'hAA) || (byte_q == 8'hEE) ||
                    (byte_q == 8'hFA) || (byte_q == 8'hFE) || (byte_q == 8'hFF);
        evt_hit   = in_ack && !is_e0 && !is_f0 && !is_junk;
        new_ev    = '{ext: ext_f, code: byte_q, make: ~brk_f};
        match     = ({ext_f, byte_q} == {cur_ext, cur_code});
        rpt       = (SUPPRESS_REPEAT != 0) && !brk_f && key_held && match;
        take      = evt_hit && !rpt;
        take_make = take && !brk_f;
    end

    // Prefix flags: E0/F0 accumulate, any other byte ends the sequence.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ext_f <= 1'b0;
            brk_f <= 1'b0;
        end else if (in_ack) begin
            if (is_e0)      ext_f <= 1'b1;
            else if (is_f0) brk_f <= 1'b1;
            else begin
                ext_f <= 1'b0;
                brk_f <= 1'b0;
            end
        end
    end

    // Held-key tracking and press counter; these update even if the queue drops.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cur_code  <= 8'h00;
            cur_ext   <= 1'b0;
            key_held  <= 1'b0;
            press_cnt <= '0;
        end else if (take_make) begin
            cur_code  <= byte_q;
            cur_ext   <= ext_f;
            key_held  <= 1'b1;
            press_cnt <= press_cnt + 1'b1;
        end else if (take && match) begin
            key_held  <= 1'b0;
        end
    end

    assign full = (level == LW'(FIFO_DEPTH));
    assign pop  = (level != '0) && evt.ready;
    assign wr   = take && (!full || pop);
    assign drop = take && full && !pop;

    // Queue storage; no reset needed since level gates every read.
    always_ff @(posedge clk) begin
        if (wr) mem[wr_ptr] <= new_ev;
    end

    // Pointers and occupancy; pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr)  wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({wr, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // Registered head so the outputs keep the last event once the queue empties.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            head <= '0;
        else if (wr && (level == '0 || (pop && level == LW'(1))))
            head <= new_ev;
        else if (pop && level > LW'(1))
            head <= mem[rd_ptr + 1'b1];
    end

    // Sticky error; a same-cycle set beats the clear.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)                  err <= 1'b0;
        else if (drop || kb_overflow) err <= 1'b1;
        else if (clr_err)             err <= 1'b0;
    end

    assign evt.valid  = (level != '0);
    assign evt.code   = head.code;
    assign evt.ext    = head.ext;
    assign evt.make   = head.make;
    assign fifo_level = level;
endmodule

// File: tb/tb_ps2_key_event_fifo.sv
// Directed bench: two instances share all stimulus, one with repeat
// suppression (a) and one without (b).
module tb_ps2_key_event_fifo;
    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic [7:0] kb_data = 8'h00;
    logic       kb_ready = 1'b0;
    logic       kb_overflow = 1'b0;
    logic       clr_err = 1'b0;
    logic       evt_ready = 1'b0;

    logic       kb_nextdata_n, kb_nextdata_n_b;
    logic [7:0] cur_code, cur_code_b;
    logic       cur_ext, cur_ext_b, key_held, key_held_b, err, err_b;
    logic [7:0] press_cnt, press_cnt_b;
    logic [3:0] fifo_level, fifo_level_b;

    int n_chk = 0;
    int n_fail = 0;

    typedef struct packed {
        logic [7:0] code;
        logic       ext;
        logic       make;
    } tev_t;

    tev_t qa[$];
    int   cnt_b = 0;
    int   ack_cnt = 0;
    bit   ack_long = 0;
    bit   prev_low = 0;

    ps2_key_event_fifo_if ifa ();
    ps2_key_event_fifo_if ifb ();
    assign ifa.ready = evt_ready;
    assign ifb.ready = evt_ready;

    ps2_key_event_fifo #(.FIFO_DEPTH(8), .CNT_W(8), .SUPPRESS_REPEAT(1)) dut_a (
        .clk(clk), .resetn(resetn), .kb_data(kb_data), .kb_ready(kb_ready),
        .kb_overflow(kb_overflow), .kb_nextdata_n(kb_nextdata_n), .evt(ifa.master),
        .cur_code(cur_code), .cur_ext(cur_ext), .key_held(key_held),
        .press_cnt(press_cnt), .fifo_level(fifo_level), .err(err), .clr_err(clr_err)
    );

    ps2_key_event_fifo #(.FIFO_DEPTH(8), .CNT_W(8), .SUPPRESS_REPEAT(0)) dut_b (
        .clk(clk), .resetn(resetn), .kb_data(kb_data), .kb_ready(kb_ready),
        .kb_overflow(kb_overflow), .kb_nextdata_n(kb_nextdata_n_b), .evt(ifb.master),
        .cur_code(cur_code_b), .cur_ext(cur_ext_b), .key_held(key_held_b),
        .press_cnt(press_cnt_b), .fifo_level(fifo_level_b), .err(err_b), .clr_err(clr_err)
    );

    always #5 clk = ~clk;

    // Record popped events and ACK strobes away from the active edge.
    always @(negedge clk) begin
        if (resetn && ifa.valid && ifa.ready) qa.push_back('{ifa.code, ifa.ext, ifa.make});
        if (resetn && ifb.valid && ifb.ready) cnt_b++;
        if (!kb_nextdata_n) begin
            ack_cnt++;
            if (prev_low) ack_long = 1;
        end
        prev_low = !kb_nextdata_n;
    end

    task automatic send_byte(input logic [7:0] b, input bit pop_in_ack);
        bit seen = 0;
        kb_data  = b;
        kb_ready = 1'b1;
        for (int t = 0; t < 20 && !seen; t++) begin
            @(posedge clk); #1;
            if (!kb_nextdata_n) seen = 1;
        end
        if (!seen) begin
            n_chk++; n_fail++;
            $display("FAIL ack_timeout: byte %h got no ack in 20 cycles", b);
        end
        if (pop_in_ack) evt_ready = 1'b1;
        @(posedge clk); #1;
        kb_ready = 1'b0;
        if (pop_in_ack) evt_ready = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1;
        qa.delete();
        cnt_b = 0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        idle(2);
        n_chk++; if (kb_nextdata_n !== 1'b1) begin n_fail++; $display("FAIL rst_nextdata: got %b want 1", kb_nextdata_n); end
        n_chk++; if (ifa.valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", ifa.valid); end
        n_chk++; if ({ifa.code, ifa.ext, ifa.make} !== 10'h0) begin n_fail++; $display("FAIL rst_head: got %h want 0", {ifa.code, ifa.ext, ifa.make}); end
        n_chk++; if ({cur_code, cur_ext, key_held} !== 10'h0) begin n_fail++; $display("FAIL rst_cur: got %h want 0", {cur_code, cur_ext, key_held}); end
        n_chk++; if ({press_cnt, fifo_level, err} !== 13'h0) begin n_fail++; $display("FAIL rst_cnt: got %h want 0", {press_cnt, fifo_level, err}); end
        resetn = 1'b1;
        idle(1);
    endtask

    task automatic test_basic();
        qa.delete();
        ack_cnt = 0; ack_long = 0;
        evt_ready = 1'b1;
        send_byte(8'h15, 0);
        n_chk++; if (key_held !== 1'b1) begin n_fail++; $display("FAIL basic_held_make: got %b want 1", key_held); end
        send_byte(8'hF0, 0);
        send_byte(8'h15, 0);
        idle(3);
        n_chk++; if (qa.size() !== 2) begin n_fail++; $display("FAIL basic_count: got %0d want 2", qa.size()); end
        else begin
            n_chk++; if (qa[0] !== {8'h15, 1'b0, 1'b1}) begin n_fail++; $display("FAIL basic_ev0: got %h want %h", qa[0], {8'h15, 2'b01}); end
            n_chk++; if (qa[1] !== {8'h15, 1'b0, 1'b0}) begin n_fail++; $display("FAIL basic_ev1: got %h want %h", qa[1], {8'h15, 2'b00}); end
        end
        n_chk++; if (press_cnt !== 8'd1) begin n_fail++; $display("FAIL basic_press: got %0d want 1", press_cnt); end
        n_chk++; if (key_held !== 1'b0) begin n_fail++; $display("FAIL basic_held_brk: got %b want 0", key_held); end
        n_chk++; if (cur_code !== 8'h15) begin n_fail++; $display("FAIL basic_cur: got %h want 15", cur_code); end
        n_chk++; if (ack_cnt !== 3 || ack_long) begin n_fail++; $display("FAIL basic_ack: got %0d long=%0d want 3 long=0", ack_cnt, ack_long); end
    endtask

    task automatic test_ext();
        logic [7:0] seq [7] = '{8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75, 8'hF0, 8'h75};
        tev_t exp [3] = '{'{8'h75, 1'b1, 1'b1}, '{8'h75, 1'b1, 1'b0}, '{8'h75, 1'b0, 1'b0}};
        qa.delete();
        evt_ready = 1'b1;
        foreach (seq[i]) send_byte(seq[i], 0);
        idle(3);
        n_chk++; if (qa.size() !== 3) begin n_fail++; $display("FAIL ext_count: got %0d want 3", qa.size()); end
        else foreach (exp[i]) begin
            n_chk++; if (qa[i] !== exp[i]) begin n_fail++; $display("FAIL ext_ev%0d: got %h want %h", i, qa[i], exp[i]); end
        end
        n_chk++; if ({cur_ext, cur_code} !== 9'h175) begin n_fail++; $display("FAIL ext_cur: got %h want 175", {cur_ext, cur_code}); end
        n_chk++; if (press_cnt !== 8'd2) begin n_fail++; $display("FAIL ext_press: got %0d want 2", press_cnt); end
    endtask

    task automatic test_repeat();
        logic [7:0] seq [5] = '{8'h1C, 8'h1C, 8'h1C, 8'hF0, 8'h1C};
        do_reset();
        evt_ready = 1'b1;
        foreach (seq[i]) send_byte(seq[i], 0);
        idle(3);
        n_chk++; if (qa.size() !== 2) begin n_fail++; $display("FAIL rpt_count_a: got %0d want 2", qa.size()); end
        else begin
            n_chk++; if (qa[1] !== {8'h1C, 1'b0, 1'b0}) begin n_fail++; $display("FAIL rpt_brk_a: got %h want %h", qa[1], {8'h1C, 2'b00}); end
        end
        n_chk++; if (press_cnt !== 8'd1) begin n_fail++; $display("FAIL rpt_press_a: got %0d want 1", press_cnt); end
        n_chk++; if (cnt_b !== 4) begin n_fail++; $display("FAIL rpt_count_b: got %0d want 4", cnt_b); end
        n_chk++; if (press_cnt_b !== 8'd3) begin n_fail++; $display("FAIL rpt_press_b: got %0d want 3", press_cnt_b); end
    endtask

    task automatic test_fifo_full();
        do_reset();
        evt_ready = 1'b0;
        for (int i = 0; i < 9; i++) send_byte(8'h10 + 8'(i), 0);
        idle(2);
        n_chk++; if (fifo_level !== 4'd8) begin n_fail++; $display("FAIL full_level: got %0d want 8", fifo_level); end
        n_chk++; if (err !== 1'b1) begin n_fail++; $display("FAIL full_err: got %b want 1", err); end
        n_chk++; if (press_cnt !== 8'd9) begin n_fail++; $display("FAIL full_press: got %0d want 9", press_cnt); end
        n_chk++; if (ifa.valid !== 1'b1 || ifa.code !== 8'h10) begin n_fail++; $display("FAIL full_head: got v=%b %h want v=1 10", ifa.valid, ifa.code); end
        evt_ready = 1'b1;
        idle(8);
        evt_ready = 1'b0;
        n_chk++; if (fifo_level !== 4'd0 || ifa.valid !== 1'b0) begin n_fail++; $display("FAIL drain_level: got %0d v=%b want 0 v=0", fifo_level, ifa.valid); end
        n_chk++; if (qa.size() !== 8) begin n_fail++; $display("FAIL drain_count: got %0d want 8", qa.size()); end
        else foreach (qa[i]) begin
            n_chk++; if (qa[i].code !== 8'h10 + 8'(i)) begin n_fail++; $display("FAIL drain_ev%0d: got %h want %h", i, qa[i].code, 8'h10 + 8'(i)); end
        end
        n_chk++; if (ifa.code !== 8'h17) begin n_fail++; $display("FAIL drain_hold: got %h want 17", ifa.code); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        evt_ready = 1'b0;
        for (int i = 0; i < 8; i++) send_byte(8'h20 + 8'(i), 0);
        idle(2);
        n_chk++; if (fifo_level !== 4'd8 || err !== 1'b0) begin n_fail++; $display("FAIL b2b_fill: got %0d err=%b want 8 err=0", fifo_level, err); end
        send_byte(8'h28, 1);
        idle(2);
        n_chk++; if (fifo_level !== 4'd8 || err !== 1'b0) begin n_fail++; $display("FAIL b2b_pushpop: got %0d err=%b want 8 err=0", fifo_level, err); end
        n_chk++; if (qa.size() !== 1 || ifa.code !== 8'h21) begin n_fail++; $display("FAIL b2b_head: got pops=%0d head=%h want 1 21", qa.size(), ifa.code); end
        kb_overflow = 1'b1; clr_err = 1'b1;
        idle(1);
        kb_overflow = 1'b0;
        n_chk++; if (err !== 1'b1) begin n_fail++; $display("FAIL err_set_wins: got %b want 1", err); end
        idle(1);
        clr_err = 1'b0;
        n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL err_clear: got %b want 0", err); end
    endtask

    task automatic test_reset_mid();
        evt_ready = 1'b0;
        send_byte(8'hF0, 0);
        resetn = 1'b0;
        #1;
        n_chk++; if (fifo_level !== 4'd0 || ifa.valid !== 1'b0 || kb_nextdata_n !== 1'b1) begin n_fail++; $display("FAIL mid_rst_q: got %0d v=%b nd=%b want 0 0 1", fifo_level, ifa.valid, kb_nextdata_n); end
        n_chk++; if ({ifa.code, cur_code, press_cnt, key_held, err} !== 26'h0) begin n_fail++; $display("FAIL mid_rst_regs: got %h want 0", {ifa.code, cur_code, press_cnt, key_held, err}); end
        @(posedge clk); #1;
        resetn = 1'b1;
        qa.delete();
        evt_ready = 1'b1;
        send_byte(8'h15, 0);
        idle(3);
        n_chk++; if (qa.size() !== 1) begin n_fail++; $display("FAIL mid_count: got %0d want 1", qa.size()); end
        else begin
            n_chk++; if (qa[0] !== {8'h15, 1'b0, 1'b1}) begin n_fail++; $display("FAIL mid_ev: got %h want %h", qa[0], {8'h15, 2'b01}); end
        end
        send_byte(8'hAA, 0);
        idle(3);
        n_chk++; if (qa.size() !== 1 || press_cnt !== 8'd1) begin n_fail++; $display("FAIL aa_drop: got %0d press=%0d want 1 1", qa.size(), press_cnt); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_ext();
        test_repeat();
        test_fifo_full();
        test_back_to_back();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/ps2_key_event_fifo.md
Name: ps2_key_event_fifo

Overview:
- Generalised successor to the top-level keyboard control FSM.
- Consumes raw scan-code bytes from ps2_keyboard through its ready/nextdata_n handshake.
- Decodes set-2 prefixes (E0 extended, F0 break) into whole key events, suppresses typematic repeats, and counts presses.
- Queues events in a parametrised FIFO with valid/ready output for downstream consumers (VGA text renderer, seven-segment driver).

Parameters:
- FIFO_DEPTH, 8, event queue depth; power of two, at least 2.
- CNT_W, 8, width of the press counter.
- SUPPRESS_REPEAT, 1, when 1, a make of the currently held key is dropped and not counted.

Ports:
- clk  in  1  system clock; all state on posedge.
- resetn  in  1  asynchronous active-low reset.
- kb_data  in  8  byte from ps2_keyboard data.
- kb_ready  in  1  ps2_keyboard ready: a byte is available.
- kb_overflow  in  1  ps2_keyboard overflow.
- kb_nextdata_n  out  1  active-low pop strobe to ps2_keyboard.
- evt_valid  out  1  FIFO non-empty.
- evt_ready  in  1  consumer accepts the head event.
- evt_code  out  8  head event scan code.
- evt_ext  out  1  head event had the E0 prefix.
- evt_make  out  1  1 = press, 0 = release.
- cur_code  out  8  code of the last accepted make.
- cur_ext  out  1  ext bit of the last accepted make.
- key_held  out  1  the cur_code key is currently down.
- press_cnt  out  CNT_W  accepted-make counter; wraps.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  number of queued events.
- err  out  1  sticky: FIFO drop or kb_overflow seen.
- clr_err  in  1  synchronous clear of err.

Behaviour:
- Reset (async, resetn=0) gives: state IDLE, kb_nextdata_n=1, FIFO empty, evt_valid=0, evt_code/evt_ext/evt_make=0, cur_code=0, cur_ext=0, key_held=0, press_cnt=0, err=0, prefix flags cleared.
- Reset mid-sequence discards partial prefixes and all queued events.
- Intake FSM:
  - IDLE: if kb_ready=1, latch kb_data into byte_q and go to ACK.
  - ACK: kb_nextdata_n=0 for exactly this one cycle; decode byte_q; go to SETTLE.
  - SETTLE: kb_nextdata_n=1; go to IDLE. This lets ready deassert or advance.
  - Maximum intake rate is one byte per 3 cycles.
  - kb_nextdata_n is low only in ACK.
- Decode, performed in ACK:
  - E0: set ext_f.
  - F0: set brk_f.
  - 00, AA, EE, FA, FE, FF: drop the byte, clear both flags, no event.
  - Any other byte forms event {ext_f, byte_q, make=~brk_f}; clear both flags.
- Make event:
  - Repeat case: if SUPPRESS_REPEAT=1, key_held=1 and {ext,code}=={cur_ext,cur_code}, do not push, do not count, no state change.
  - Otherwise: cur_code/cur_ext <= event; key_held <= 1; press_cnt <= press_cnt+1 (mod 2^CNT_W); push.
- Break event: always pushed. If {ext,code} matches cur, key_held <= 0; otherwise key_held is unchanged.
- FIFO:
  - First-word fall-through; evt_* show the head entry whenever evt_valid=1.
  - evt_valid = (fifo_level != 0).
  - Pop on evt_valid && evt_ready.
  - Push when full with a same-cycle pop: both happen, level unchanged.
  - Push when full without a pop: event lost, err <= 1. cur_code, key_held and press_cnt still update.
  - Pop when empty: ignored.
  - Pointers wrap modulo FIFO_DEPTH.
  - evt_* hold their last value when empty (not reset-cleared except at reset).
- Latency: kb_ready sampled high at edge N; push at edge N+1 (end of ACK); evt_valid=1 after edge N+1 if the FIFO was empty.
- err:
  - Set by a FIFO drop or by kb_overflow=1 on any cycle.
  - clr_err=1 clears it unless a set condition is present in the same cycle; set wins.

Test Plan:
- Bytes 15, F0, 15 with evt_ready=1 -> two events: {code=15,ext=0,make=1} then {15,0,0}; press_cnt=1; key_held=1 then 0; cur_code=15; kb_nextdata_n low exactly 3 single cycles.
- E0 75, E0 F0 75 -> events {75,1,1} and {75,1,0}; cur_ext=1; F0 without E0 after this gives ext=0.
- SUPPRESS_REPEAT=1: 1C, 1C, 1C, F0 1C -> 2 events only (make, break); press_cnt=1. Rerun with SUPPRESS_REPEAT=0 -> 4 events; press_cnt=3.
- FIFO_DEPTH=8, evt_ready=0, 9 distinct makes -> fifo_level=8, err=1, press_cnt=9, head code = first make. Then evt_ready=1 for 8 cycles -> level 0, evt_valid=0.
- Full FIFO, push and pop in the same cycle -> level stays 8, no err. Then clr_err with kb_overflow=1 in the same cycle -> err stays 1.
- Send F0, assert resetn=0 for 1 cycle mid-operation, then send 15 -> all outputs at reset values, then one make event {15,0,1}; AA alone -> no event.
